// File: rtl/ad724_pkg.sv
// Shared definitions for the AD724 PAL/NTSC standard sequencer: FSM state
// encoding, CTRLAD724 register bit positions, video standard constants and
// reset values of the AD724 pins.
package ad724_pkg;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_BLANK_WAIT   = 3'd1,
      ST_BLANK        = 3'd2,
      ST_XTAL         = 3'd3,
      ST_SETTLE       = 3'd4,
      ST_MODE         = 3'd5,
      ST_UNBLANK_WAIT = 3'd6,
      ST_DONE         = 3'd7
   } state_e;

   // CTRLAD724 read-back bit positions
   localparam int BIT_TGT     = 0;
   localparam int BIT_APPLIED = 1;
   localparam int BIT_PEND    = 2;
   localparam int BIT_BUSY    = 7;

   // Video standard encoding (also the level of the AD724 STND pin)
   localparam logic STD_PAL  = 1'b0;
   localparam logic STD_NTSC = 1'b1;

   // Power-on values: PAL crystal selected, PAL mode
   localparam logic RST_TARGET = STD_PAL;
   localparam logic RST_XTAL   = 1'b1;
   localparam logic RST_MODE   = STD_PAL;

   // Crystal select level for a standard (1 selects the PAL crystal)
   function automatic logic xtal_for_std(input logic std);
      return (std != STD_NTSC);
   endfunction

endpackage

// File: rtl/ad724_std_sequencer_vsync_edge_sync.sv
// Brings an asynchronous vsync into the clk domain through two flip-flops and
// produces a one-cycle pulse on each synchronised rising edge.
module vsync_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic [1:0] sync_q;
   logic       prev_q;

   // Two-stage synchroniser plus a delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], async_i};
         prev_q <= sync_q[1];
      end
   end

   assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ad724_std_sequencer.sv
// AD724 PAL/NTSC standard sequencer. Owns the CTRLAD724 register; on a change
// of target standard it blanks video, switches the crystal, waits for the
// oscillator to settle, switches the STND pin and unblanks.
// Optional feature macro: AD724_VSYNC_ALIGN_EN -- when defined, blanking and
// unblanking wait for a vsync rising edge (bounded by VSYNC_TIMEOUT); when
// undefined both wait states last one cycle and vsync is ignored.
module ad724_std_sequencer
   import ad724_pkg::*;
#(
   parameter logic [7:0] REG_ADDR      = 8'hFB,
   parameter int         SETTLE_CYCLES = 28000,
   parameter int         VSYNC_TIMEOUT = 600000
) (
   input  logic       clk,
   input  logic       poweron_rst_n,
   input  logic [7:0] zxuno_addr,
   input  logic       zxuno_regrd,
   input  logic       zxuno_regwr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       oe,
   input  logic       vsync,
   output logic       ad724_xtal,
   output logic       ad724_mode,
   output logic       video_blank,
   output logic       busy
);

   // Settle counter holds SETTLE_CYCLES-1 down to 0
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic             target_q, target_d;
   logic             applied_q, applied_d;
   logic             pending_q, pending_d;
   logic             tl_q, tl_d;
   logic             xtal_q, xtal_d;
   logic             mode_q, mode_d;
   logic             blank_q, blank_d;
   logic             busy_q, busy_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic             wr_hit;
   logic             wait_done;
   logic [6:0]       din_unused;

   assign wr_hit     = zxuno_regwr && (zxuno_addr == REG_ADDR);
   assign din_unused = din[7:1];

`ifdef AD724_VSYNC_ALIGN_EN
   // Timeout counter holds 0 .. VSYNC_TIMEOUT-1 and saturates at the top
   localparam int TMO_W = (VSYNC_TIMEOUT > 1) ? $clog2(VSYNC_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(VSYNC_TIMEOUT - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             vs_rise;
   logic             in_wait, enter_wait;

   vsync_edge_sync u_vsync_sync (
      .clk     (clk),
      .rst_n   (poweron_rst_n),
      .async_i (vsync),
      .rise_o  (vs_rise)
   );

   assign in_wait    = (state_q == ST_BLANK_WAIT) || (state_q == ST_UNBLANK_WAIT);
   assign enter_wait = ((state_d == ST_BLANK_WAIT) || (state_d == ST_UNBLANK_WAIT))
                       && (state_d != state_q);
   // A vsync edge coinciding with the timeout takes the same exit
   assign wait_done  = vs_rise || (tmo_q == TMO_MAX);

   // Timeout counter: cleared on entry to a wait state, counts while waiting
   always_comb begin
      tmo_d = tmo_q;
      if (enter_wait) begin
         tmo_d = '0;
      end else if (in_wait && (tmo_q != TMO_MAX)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   // Timeout counter register
   always_ff @(posedge clk or negedge poweron_rst_n) begin
      if (!poweron_rst_n) tmo_q <= '0;
      else                tmo_q <= tmo_d;
   end
`else
   logic vsync_unused;
   assign vsync_unused = vsync;
   assign wait_done    = 1'b1;
`endif

   // Next-state, register update and registered pin values
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      applied_d = applied_q;
      pending_d = pending_q;
      tl_d      = tl_q;
      xtal_d    = xtal_q;
      mode_d    = mode_q;
      blank_d   = blank_q;
      busy_d    = busy_q;
      settle_d  = settle_q;

      unique case (state_q)
         ST_IDLE: begin
            if (target_q != applied_q) begin
               state_d   = ST_BLANK_WAIT;
               tl_d      = target_q;
               pending_d = 1'b0;
            end
         end
         ST_BLANK_WAIT: begin
            busy_d = 1'b1;
            if (wait_done) state_d = ST_BLANK;
         end
         ST_BLANK: begin
            blank_d = 1'b1;
            state_d = ST_XTAL;
         end
         ST_XTAL: begin
            xtal_d   = xtal_for_std(tl_q);
            settle_d = SETTLE_LOAD;
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == '0) state_d = ST_MODE;
            else                settle_d = settle_q - SET_W'(1);
         end
         ST_MODE: begin
            mode_d    = tl_q;
            applied_d = tl_q;
            state_d   = ST_UNBLANK_WAIT;
         end
         ST_UNBLANK_WAIT: begin
            if (wait_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            blank_d = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A write never touches the sequence in flight; it only flags that a
      // further change is queued once the FSM is back in IDLE.
      if (wr_hit) begin
         target_d = din[0];
         if ((state_q != ST_IDLE) || (state_d != ST_IDLE)) pending_d = 1'b1;
      end
   end

   // State and output registers; reset aborts any sequence in progress
   always_ff @(posedge clk or negedge poweron_rst_n) begin
      if (!poweron_rst_n) begin
         state_q   <= ST_IDLE;
         target_q  <= RST_TARGET;
         applied_q <= RST_TARGET;
         pending_q <= 1'b0;
         tl_q      <= RST_TARGET;
         xtal_q    <= RST_XTAL;
         mode_q    <= RST_MODE;
         blank_q   <= 1'b0;
         busy_q    <= 1'b0;
         settle_q  <= '0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         applied_q <= applied_d;
         pending_q <= pending_d;
         tl_q      <= tl_d;
         xtal_q    <= xtal_d;
         mode_q    <= mode_d;
         blank_q   <= blank_d;
         busy_q    <= busy_d;
         settle_q  <= settle_d;
      end
   end

   // Register read-back assembled from state bits
   always_comb begin
      dout              = 8'h00;
      dout[BIT_TGT]     = target_q;
      dout[BIT_APPLIED] = applied_q;
      dout[BIT_PEND]    = pending_q;
      dout[BIT_BUSY]    = busy_q;
   end

   assign oe          = (zxuno_addr == REG_ADDR) && zxuno_regrd;
   assign ad724_xtal  = xtal_q;
   assign ad724_mode  = mode_q;
   assign video_blank = blank_q;
   assign busy        = busy_q;

endmodule
